// File: rtl/cache_pkg.sv
// cache_pkg: shared constants and FSM state type for the instruction cache
package cache_pkg;
  localparam int LINE_BYTES = 64;
  localparam int BEATS = 8;
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic READ = 1'b1;
  localparam logic [3:0] MEMORY = 4'b0001;
  typedef enum logic [1:0] {LOOKUP, ACK, REQ, FILL} state_t;
endpackage

// File: rtl/cache_if.sv
// cache_if: system bus request/response channel between the cache and memory
interface cache_if #(parameter int DW = 64, parameter int TW = 13);
  logic bus_reqcyc;
  logic [63:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic bus_reqack;
  logic bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic bus_respack;
  modport master(
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
  modport slave(
    input bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/cache_line_array.sv
// cache_line_array: per-line valid/tag/data storage with one read port and a beat-write port
module cache_line_array import cache_pkg::*; #(
  parameter int NUM_LINES = 16,
  parameter int DW = 64,
  parameter int IW = $clog2(NUM_LINES),
  parameter int TW = 64 - OFF_W - IW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IW-1:0]     rd_index,
  input  logic [BEAT_W-1:0] rd_word,
  output logic              rd_valid,
  output logic [TW-1:0]     rd_tag,
  output logic [DW-1:0]     rd_data,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_index,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [TW-1:0]     wr_tag,
  input  logic [DW-1:0]     wr_data
);
  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0] tags [NUM_LINES];
  logic [DW-1:0] data [NUM_LINES][BEATS];
  logic last;
  assign last = wr_beat == BEAT_W'(BEATS - 1);
  // the line is invalid while being filled and becomes valid with the final beat
  always_ff @(posedge clk)
    if (reset) valid <= '0;
    else if (wr_en) valid[wr_index] <= last;
  always_ff @(posedge clk)
    if (wr_en) begin
      data[wr_index][wr_beat] <= wr_data;
      if (last) tags[wr_index] <= wr_tag;
    end
  assign rd_valid = valid[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_data = data[rd_index][rd_word];
endmodule

// File: rtl/cache.sv
// cache: direct-mapped read-only instruction cache with 64-byte line fills over a 64-bit bus
module cache import cache_pkg::*; #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH = 13,
  parameter int NUM_LINES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  input  logic [63:0] stackptr,
  cache_if.master     bus,
  output logic        data_ack,
  output logic [31:0] instr_reg
);
  localparam int IW = $clog2(NUM_LINES);
  localparam int TW = 64 - OFF_W - IW;
  state_t state, state_n;
  logic [BEAT_W-1:0] beat, beat_n;
  logic data_ack_n, reqcyc, reqcyc_n;
  logic [31:0] instr_n;
  logic [63:0] req, req_n;
  logic [BUS_TAG_WIDTH-1:0] reqtag, reqtag_n;
  logic rd_valid, hit, wr_en;
  logic [TW-1:0] rd_tag;
  logic [BUS_DATA_WIDTH-1:0] rd_data;
  logic unused;
  assign unused = ^{stackptr, bus.bus_resptag, pc[1:0]};
  cache_line_array #(.NUM_LINES(NUM_LINES), .DW(BUS_DATA_WIDTH)) lines (
    .clk(clk),
    .reset(reset),
    .rd_index(pc[OFF_W +: IW]),
    .rd_word(pc[OFF_W-1 -: BEAT_W]),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .wr_en(wr_en),
    .wr_index(pc[OFF_W +: IW]),
    .wr_beat(beat),
    .wr_tag(pc[63 -: TW]),
    .wr_data(bus.bus_resp)
  );
  assign hit = rd_valid && rd_tag == pc[63 -: TW];
  assign wr_en = state == FILL && bus.bus_respcyc;
  assign bus.bus_respack = bus.bus_respcyc;
  assign bus.bus_reqcyc = reqcyc;
  assign bus.bus_req = req;
  assign bus.bus_reqtag = reqtag;
  always_ff @(posedge clk)
    if (reset) begin
      state <= LOOKUP;
      beat <= '0;
      data_ack <= 1'b0;
      reqcyc <= 1'b0;
      instr_reg <= '0;
      req <= '0;
      reqtag <= '0;
    end else begin
      state <= state_n;
      beat <= beat_n;
      data_ack <= data_ack_n;
      reqcyc <= reqcyc_n;
      instr_reg <= instr_n;
      req <= req_n;
      reqtag <= reqtag_n;
    end
  // pc is held by fetch during a miss, so it also addresses the line being filled
  always_comb begin
    state_n = state;
    beat_n = beat;
    data_ack_n = 1'b0;
    reqcyc_n = reqcyc;
    instr_n = instr_reg;
    req_n = req;
    reqtag_n = reqtag;
    unique case (state)
      LOOKUP: begin
        data_ack_n = hit;
        instr_n = hit ? (pc[2] ? rd_data[63:32] : rd_data[31:0]) : instr_reg;
        reqcyc_n = !hit;
        req_n = hit ? req : {pc[63:OFF_W], OFF_W'(0)};
        reqtag_n = hit ? reqtag : BUS_TAG_WIDTH'({READ, MEMORY, 8'h00});
        state_n = hit ? ACK : REQ;
      end
      ACK: state_n = LOOKUP;
      REQ: begin
        reqcyc_n = !bus.bus_reqack;
        state_n = bus.bus_reqack ? FILL : REQ;
      end
      FILL: begin
        beat_n = bus.bus_respcyc ? beat + 1'b1 : beat;
        state_n = bus.bus_respcyc && beat == BEAT_W'(BEATS - 1) ? LOOKUP : FILL;
      end
      default: state_n = LOOKUP;
    endcase
  end
endmodule

// File: tb/tb_cache.sv
// tb_cache: directed self-checking bench for the instruction cache with a scripted bus responder
module tb_cache;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [63:0] pc = '0;
  logic [63:0] stackptr = '0;
  logic data_ack;
  logic [31:0] instr_reg;
  int n_cmp = 0;
  int n_err = 0;
  cache_if bus();
  cache dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .stackptr(stackptr),
    .bus(bus),
    .data_ack(data_ack),
    .instr_reg(instr_reg)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ins(input logic [63:0] a);
    return a == 64'h2084 ? 32'h0000_8067 : a[31:0] ^ 32'hC0DE_0000;
  endfunction
  function automatic logic [63:0] beat_of(input logic [63:0] a);
    return {ins(a + 64'd4), ins(a)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input string tag, input logic [63:0] a, input int lat);
    int n = 0;
    pc = a;
    do begin
      tick();
      n++;
    end while (!data_ack && n < 40);
    check({tag, " ack"}, 64'(data_ack), 64'd1);
    check({tag, " latency"}, 64'(n), 64'(lat));
    check({tag, " instr"}, 64'(instr_reg), 64'(ins(a)));
  endtask
  task automatic await_req(input string tag, input logic [63:0] line);
    int n = 0;
    while (!bus.bus_reqcyc && n < 40) begin
      tick();
      n++;
    end
    check({tag, " reqcyc"}, 64'(bus.bus_reqcyc), 64'd1);
    check({tag, " req"}, bus.bus_req, line);
    check({tag, " reqtag"}, 64'(bus.bus_reqtag), 64'h1100);
  endtask
  task automatic serve(input string tag, input logic [63:0] line, input int delay, input int beats);
    for (int i = 0; i < delay; i++) begin
      tick();
      check({tag, " reqcyc held"}, 64'(bus.bus_reqcyc), 64'd1);
      check({tag, " req stable"}, bus.bus_req, line);
    end
    bus.bus_reqack = 1'b1;
    tick();
    bus.bus_reqack = 1'b0;
    check({tag, " reqcyc drop"}, 64'(bus.bus_reqcyc), 64'd0);
    for (int b = 0; b < beats; b++) begin
      bus.bus_respcyc = 1'b1;
      bus.bus_resp = beat_of(line + 64'(8 * b));
      #1 check({tag, " respack"}, 64'(bus.bus_respack), 64'd1);
      tick();
    end
    bus.bus_respcyc = 1'b0;
  endtask
  initial begin
    bus.bus_reqack = 1'b0;
    bus.bus_respcyc = 1'b0;
    bus.bus_resp = '0;
    bus.bus_resptag = '0;
    tick();
    tick();
    check("rst data_ack", 64'(data_ack), 64'd0);
    check("rst reqcyc", 64'(bus.bus_reqcyc), 64'd0);
    check("rst instr", 64'(instr_reg), 64'd0);
    check("rst req", bus.bus_req, 64'd0);
    check("rst reqtag", 64'(bus.bus_reqtag), 64'd0);
    pc = 64'h1000;
    reset = 1'b0;
    await_req("cold", 64'h1000);
    serve("cold", 64'h1000, 0, 8);
    fetch("cold", 64'h1000, 1);
    check("cold instr literal", 64'(instr_reg), 64'hC0DE_1000);
    fetch("hit", 64'h1004, 2);
    check("hit instr literal", 64'(instr_reg), 64'hC0DE_1004);
    check("hit no req", 64'(bus.bus_reqcyc), 64'd0);
    for (int i = 0; i < 16; i++) fetch("cross", 64'h1000 + 64'(4 * i), 2);
    check("cross no req", 64'(bus.bus_reqcyc), 64'd0);
    pc = 64'h1040;
    await_req("cross next", 64'h1040);
    serve("cross next", 64'h1040, 0, 8);
    fetch("cross next", 64'h1040, 1);
    pc = 64'h2084;
    await_req("handshake", 64'h2080);
    serve("handshake", 64'h2080, 5, 8);
    fetch("handshake", 64'h2084, 1);
    check("handshake instr", 64'(instr_reg), 64'h0000_8067);
    pc = 64'h1400;
    await_req("conflict", 64'h1400);
    serve("conflict", 64'h1400, 0, 8);
    fetch("conflict", 64'h1400, 1);
    pc = 64'h1000;
    await_req("conflict evict", 64'h1000);
    serve("midfill", 64'h1000, 0, 3);
    for (int b = 3; b < 8; b++) begin
      bus.bus_respcyc = 1'b1;
      bus.bus_resp = beat_of(64'h1000 + 64'(8 * b));
      reset = b == 3;
      #1 check("midfill late respack", 64'(bus.bus_respack), 64'd1);
      tick();
      reset = 1'b0;
      check("midfill no ack", 64'(data_ack), 64'd0);
    end
    bus.bus_respcyc = 1'b0;
    await_req("after reset", 64'h1000);
    serve("refill", 64'h1000, 0, 8);
    fetch("refill", 64'h1000, 1);
    fetch("refill hi", 64'h103C, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
